// File: rtl/branch_pkg.sv
// branch_pkg: shared types and helpers for the branch resolution slice.
//   cond_e     - 3-bit branch condition codes carried with each branch.
//   SNT..ST    - 2-bit saturating direction counter states.
//   BHT_RESET  - value every predictor entry takes on reset.
//   cond_eval  - evaluates a condition code against the ALU Z/N flags.
package branch_pkg;

    typedef enum logic [2:0] {
        COND_GE = 3'b000,  // !N, the original "branch if not negative"
        COND_EQ = 3'b001,
        COND_NE = 3'b010,
        COND_LT = 3'b011,
        COND_AL = 3'b100,
        COND_LE = 3'b101,
        COND_GT = 3'b110,
        COND_NV = 3'b111
    } cond_e;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam logic [1:0] BHT_RESET = WNT;

    function automatic logic cond_eval(input cond_e cond, input logic z, input logic n);
        logic res;
        res = 1'b0;
        unique case (cond)
            COND_GE: res = !n;
            COND_EQ: res = z;
            COND_NE: res = !z;
            COND_LT: res = n;
            COND_AL: res = 1'b1;
            COND_LE: res = z | n;
            COND_GT: res = !z & !n;
            COND_NV: res = 1'b0;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// branch_resolve_unit_if: execute-stage bundle between the pipeline and the
// branch resolution unit.
//   master - pipeline side: drives the execute instruction, receives redirect.
//   slave  - resolution unit side.
//   Signals: validE, stallE, branchE, jumpE, condE, zeroE, negativeE, pcE,
//            targetE, predTakenE (to unit); pcSrcE, redirectPcE, flushE (back).
interface branch_resolve_unit_if #(
    parameter int unsigned PC_W = 32
);
    logic            validE;
    logic            stallE;
    logic            branchE;
    logic            jumpE;
    logic [2:0]      condE;
    logic            zeroE;
    logic            negativeE;
    logic [PC_W-1:0] pcE;
    logic [PC_W-1:0] targetE;
    logic            predTakenE;
    logic            pcSrcE;
    logic [PC_W-1:0] redirectPcE;
    logic            flushE;

    modport master (
        output validE, stallE, branchE, jumpE, condE, zeroE, negativeE,
               pcE, targetE, predTakenE,
        input  pcSrcE, redirectPcE, flushE
    );

    modport slave (
        input  validE, stallE, branchE, jumpE, condE, zeroE, negativeE,
               pcE, targetE, predTakenE,
        output pcSrcE, redirectPcE, flushE
    );
endinterface

// File: rtl/branch_history_table.sv
// branch_history_table: direct-mapped array of 2-bit saturating direction
// counters. Combinational read (no bypass of a same-cycle write), trained on
// the rising edge.
//   clk, rst  - clock, synchronous active-high reset (all entries -> BHT_RESET)
//   rd_idx    - fetch lookup index; rd_taken = counter MSB
//   wr_en     - train entry wr_idx toward wr_taken
module branch_history_table
    import branch_pkg::*;
#(
    parameter  int unsigned DEPTH = 64,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);
    logic [1:0] ctr [DEPTH];

    assign rd_taken = ctr[rd_idx][1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ctr[i] <= BHT_RESET;
            end
        end else if (wr_en) begin
            if (wr_taken) begin
                if (ctr[wr_idx] != ST) ctr[wr_idx] <= ctr[wr_idx] + 2'd1;
            end else begin
                if (ctr[wr_idx] != SNT) ctr[wr_idx] <= ctr[wr_idx] - 2'd1;
            end
        end
    end
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: execute-stage branch resolution with per-branch
// condition codes, 2-bit predictor table, mispredict redirect and wrapping
// performance counters.
//   clk, rst         - clock, synchronous active-high reset
//   pcF / predTakenF - fetch-side prediction lookup (combinational)
//   ex               - execute bundle (slave): instruction in, redirect out
//   branchCount      - active branches + jumps (wraps)
//   mispredictCount  - active cycles that redirected (wraps)
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int unsigned PC_W      = 32,
    parameter int unsigned BHT_DEPTH = 64,
    parameter int unsigned PC_STEP   = 4,
    parameter int unsigned CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PC_W-1:0]      pcF,
    output logic                 predTakenF,
    branch_resolve_unit_if.slave ex,
    output logic [CNT_W-1:0]     branchCount,
    output logic [CNT_W-1:0]     mispredictCount
);
    localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

    logic active;
    logic is_branch;
    logic cond_true;
    logic taken;
    logic bht_taken;
    logic unused_pcf_bits;

    // Only the word-index bits of the fetch PC address the table.
    assign unused_pcf_bits = ^{pcF[PC_W-1:IDX_W+2], pcF[1:0]};

    assign active    = ex.validE & !ex.stallE & !rst;
    // With both class bits set the instruction is handled as a jump.
    assign is_branch = ex.branchE & !ex.jumpE;
    assign cond_true = cond_eval(cond_e'(ex.condE), ex.zeroE, ex.negativeE);
    assign taken     = ex.jumpE | (ex.branchE & cond_true);

    branch_history_table #(
        .DEPTH (BHT_DEPTH)
    ) u_bht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (pcF[IDX_W+1:2]),
        .rd_taken (bht_taken),
        .wr_en    (active & is_branch),
        .wr_idx   (ex.pcE[IDX_W+1:2]),
        .wr_taken (taken)
    );

    assign predTakenF = rst ? 1'b0 : bht_taken;

    always_comb begin
        ex.pcSrcE      = 1'b0;
        ex.redirectPcE = ex.targetE;
        if (rst) begin
            ex.redirectPcE = '0;
        end else if (active) begin
            if (ex.jumpE) begin
                ex.pcSrcE = !ex.predTakenE;
            end else if (ex.branchE && (taken != ex.predTakenE)) begin
                ex.pcSrcE = 1'b1;
                // Predicted taken but fell through: resume at the next instruction.
                if (!taken) ex.redirectPcE = ex.pcE + PC_W'(PC_STEP);
            end
        end
    end

    assign ex.flushE = ex.pcSrcE;

    always_ff @(posedge clk) begin
        if (rst) begin
            branchCount     <= '0;
            mispredictCount <= '0;
        end else begin
            if (active && (ex.branchE || ex.jumpE)) branchCount <= branchCount + CNT_W'(1);
            if (ex.pcSrcE) mispredictCount <= mispredictCount + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed + randomized bench for branch_resolve_unit
// with a behavioural reference model (predictor array, counters, redirect rules).
module tb_branch_resolve_unit;
    localparam int unsigned PC_W  = 32;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             rst;
    logic [PC_W-1:0]  pcF;
    logic             predTakenF;
    logic [CNT_W-1:0] branchCount;
    logic [CNT_W-1:0] mispredictCount;

    branch_resolve_unit_if #(.PC_W(PC_W)) bus ();

    branch_resolve_unit #(
        .PC_W      (PC_W),
        .BHT_DEPTH (DEPTH),
        .PC_STEP   (4),
        .CNT_W     (CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pcF             (pcF),
        .predTakenF      (predTakenF),
        .ex              (bus.slave),
        .branchCount     (branchCount),
        .mispredictCount (mispredictCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int bht [DEPTH];
    int m_bc = 0;
    int m_mc = 0;

    function automatic bit cond_ok(input bit [2:0] c, input bit z, input bit n);
        case (c)
            3'd0: return !n;
            3'd1: return z;
            3'd2: return !z;
            3'd3: return n;
            3'd4: return 1'b1;
            3'd5: return z || n;
            3'd6: return !z && !n;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % DEPTH);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input bit s, input bit b, input bit j,
                         input bit [2:0] c, input bit z, input bit n,
                         input logic [31:0] pe, input logic [31:0] tg,
                         input bit p, input logic [31:0] pf);
        bus.validE     = v;
        bus.stallE     = s;
        bus.branchE    = b;
        bus.jumpE      = j;
        bus.condE      = c;
        bus.zeroE      = z;
        bus.negativeE  = n;
        bus.pcE        = pe;
        bus.targetE    = tg;
        bus.predTakenE = p;
        pcF            = pf;
    endtask

    // One cycle: check combinational outputs against the model, clock,
    // advance the model, check registered state. Called just after a negedge.
    task automatic step(input string tag);
        bit act, tk, esrc, etf;
        logic [31:0] epc;
        #1;
        act  = bus.validE && !bus.stallE && !rst;
        tk   = bus.jumpE || (bus.branchE && cond_ok(bus.condE, bus.zeroE, bus.negativeE));
        esrc = 1'b0;
        epc  = bus.targetE;
        if (rst) epc = 32'h0;
        else if (act) begin
            if (bus.jumpE) esrc = !bus.predTakenE;
            else if (bus.branchE && (tk != bus.predTakenE)) begin
                esrc = 1'b1;
                if (!tk) epc = bus.pcE + 32'd4;
            end
        end
        etf = rst ? 1'b0 : (bht[idx_of(pcF)] >= 2);
        check({tag, ".pcSrcE"}, {31'b0, bus.pcSrcE}, {31'b0, esrc});
        check({tag, ".flushE"}, {31'b0, bus.flushE}, {31'b0, esrc});
        check({tag, ".redirectPcE"}, bus.redirectPcE, epc);
        check({tag, ".predTakenF"}, {31'b0, predTakenF}, {31'b0, etf});
        @(posedge clk);
        if (rst) begin
            foreach (bht[i]) bht[i] = 1;
            m_bc = 0;
            m_mc = 0;
        end else if (act) begin
            if (bus.branchE || bus.jumpE) m_bc = (m_bc + 1) % (1 << CNT_W);
            if (esrc) m_mc = (m_mc + 1) % (1 << CNT_W);
            if (bus.branchE && !bus.jumpE) begin
                if (tk) bht[idx_of(bus.pcE)] = (bht[idx_of(bus.pcE)] < 3) ? bht[idx_of(bus.pcE)] + 1 : 3;
                else    bht[idx_of(bus.pcE)] = (bht[idx_of(bus.pcE)] > 0) ? bht[idx_of(bus.pcE)] - 1 : 0;
            end
        end
        #1;
        etf = rst ? 1'b0 : (bht[idx_of(pcF)] >= 2);
        check({tag, ".branchCount"}, {28'b0, branchCount}, 32'(m_bc));
        check({tag, ".mispredictCount"}, {28'b0, mispredictCount}, 32'(m_mc));
        check({tag, ".predTakenF_next"}, {31'b0, predTakenF}, {31'b0, etf});
        @(negedge clk);
    endtask

    initial begin
        foreach (bht[i]) bht[i] = 1;
        rst = 1'b1;
        drive(1, 0, 1, 0, 3'd4, 0, 0, 32'h40, 32'h200, 0, 32'h40);
        @(negedge clk);
        // Reset with a mispredicting branch in execute: outputs forced low, branch discarded
        step("reset");
        rst = 1'b0;

        // Legacy GE branch at 0x40, N=0, predicted not-taken -> redirect to target
        drive(1, 0, 1, 0, 3'd0, 0, 0, 32'h40, 32'h1000, 0, 32'h40);
        step("ge_first");
        check("ge_first.mc_is_1", {28'b0, mispredictCount}, 32'd1);
        check("ge_first.bc_is_1", {28'b0, branchCount}, 32'd1);
        check("ge_first.predF_is_1", {31'b0, predTakenF}, 32'd1);

        // Three correctly predicted taken resolutions, then a not-taken mispredict
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 1, 0, 3'd0, 0, 0, 32'h40, 32'h1000, 1, 32'h40);
            step($sformatf("ge_taken%0d", i));
        end
        drive(1, 0, 1, 0, 3'd0, 0, 1, 32'h40, 32'h1000, 1, 32'h40);
        step("ge_not_taken");

        // Condition-code sweep, each on its own table entry
        for (int c = 0; c < 8; c++) begin
            for (int zn = 0; zn < 4; zn++) begin
                drive(1, 0, 1, 0, 3'(c), zn[1], zn[0], 32'(32'h100 + 4 * (c * 4 + zn)),
                      32'h2000 + 32'(c), 0, 32'h0);
                step($sformatf("cond%0d_zn%0d", c, zn));
            end
        end

        // Jump predicted taken at a fresh 01 entry: no redirect, counted, entry untouched
        drive(1, 0, 0, 1, 3'd7, 0, 0, 32'h80, 32'h3000, 1, 32'h80);
        step("jump_pred");
        drive(1, 0, 1, 1, 3'd7, 0, 0, 32'h80, 32'h3004, 0, 32'h80);
        step("jump_both_bits");

        // Stall a mispredicted branch for 3 cycles, then release once
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 1, 0, 3'd4, 0, 0, 32'hC0, 32'h4000, 0, 32'hC0);
            step($sformatf("stall%0d", i));
        end
        drive(1, 0, 1, 0, 3'd4, 0, 0, 32'hC0, 32'h4000, 0, 32'hC0);
        step("stall_release");

        // Fall-through wrap at the top of the address space
        drive(1, 0, 1, 0, 3'd7, 0, 0, 32'hFFFF_FFFC, 32'h10, 1, 32'h0);
        step("pc_wrap");

        // Counter wrap: 16 branches after reset
        rst = 1'b1;
        drive(0, 0, 0, 0, 3'd0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        step("reset2");
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive(1, 0, 1, 0, 3'd7, 0, 0, 32'h200, 32'h0, 0, 32'h200);
            step($sformatf("wrap%0d", i));
        end
        check("wrap.bc_zero", {28'b0, branchCount}, 32'd0);

        // Train entries taken, then reset mid-stream and probe them
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 1, 0, 3'd4, 0, 0, 32'(32'h300 + 4 * i), 32'h0, 0, 32'h300);
            step($sformatf("pretrain%0d", i));
        end
        rst = 1'b1;
        drive(1, 0, 1, 0, 3'd4, 0, 0, 32'h300, 32'h5000, 0, 32'h300);
        step("reset_mid");
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 3'd0, 0, 0, 32'h0, 32'h0, 0, 32'(32'h300 + 4 * i));
            step($sformatf("post_reset%0d", i));
        end

        // Randomized traffic on a small set of colliding indices
        for (int i = 0; i < 300; i++) begin
            logic [31:0] pe, pf;
            pe  = 32'($urandom_range(0, 15)) << 2;
            pf  = ($urandom_range(0, 3) == 0) ? pe : (32'($urandom_range(0, 15)) << 2);
            rst = ($urandom_range(0, 39) == 0);
            drive(1'($urandom_range(0, 5) != 0), 1'($urandom_range(0, 4) == 0),
                  1'($urandom), 1'($urandom_range(0, 4) == 0), 3'($urandom),
                  1'($urandom), 1'($urandom), pe, $urandom, 1'($urandom), pf);
            step($sformatf("rand%0d", i));
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
